config_chain_loader: RTL and testbench
======================================

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 5, SHALL set the number of ConfigCell bits in the serial chain being loaded (legal 1..4096).
REQ-002 Parameter WORD_W, default 32, SHALL set the host word width.
REQ-003 Config_Clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Config_Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  single-cycle load request; sampled only in IDLE, DONE or ERROR.
REQ-006 verify_en  input  1  SHALL be captured with start and enables the readback pass.
REQ-007 word_valid  input  1  host word available.
REQ-008 word_ready  output  1  loader accepts a word this cycle.
REQ-009 word_data  input  WORD_W  host configuration word.
REQ-010 cfg_enable  output  1  chain advances one bit at the next edge when high.
REQ-011 cfg_data  output  1  bit presented to the ConfigIn of the first chain cell.
REQ-012 cfg_return  input  1  ConfigOut of the last chain cell, pre-shift value.
REQ-013 busy, done, error  output  1 each  status levels.

Function
REQ-014 States SHALL be IDLE, FETCH, SHIFT, VERIFY, DONE, ERROR.
REQ-015 IDLE/DONE/ERROR + start: next state FETCH, clear done/error, load remaining=CHAIN_LEN, CRC registers to 0xFFFF.
REQ-016 start while busy SHALL be ignored.
REQ-017 FETCH: word_ready=1, cfg_enable=0; on word_valid&word_ready latch word_data, go SHIFT.
REQ-018 SHIFT: cfg_enable=1 for min(WORD_W, remaining) consecutive cycles, cfg_data=latched word bit i, LSB first; remaining decrements by 1 per cycle.
REQ-019 Upper bits of a final partial word SHALL be discarded.
REQ-020 SHIFT end: remaining>0 -> FETCH; remaining=0 -> VERIFY if verify_en captured, else DONE.
REQ-021 Each bit driven in SHIFT SHALL update CRC_A (CRC-16-CCITT, poly 0x1021, init 0xFFFF, MSB-first bit-serial).
REQ-022 VERIFY: cfg_enable=1 for exactly CHAIN_LEN cycles, cfg_data=cfg_return (recirculate), each cfg_return bit updates CRC_B.
REQ-023 VERIFY end: CRC_A==CRC_B -> DONE, else ERROR.
REQ-024 busy=1 exactly in FETCH, SHIFT, VERIFY; done=1 only in DONE; error=1 only in ERROR.
REQ-025 word_ready SHALL be 0 outside FETCH; host stall holds FETCH with cfg_enable=0 indefinitely.
REQ-026 cfg_data SHALL be 0 whenever cfg_enable=0.
REQ-027 Unstalled load latency: start at cycle 0 -> first cfg_enable at cycle 2; total = 1 + ceil(CHAIN_LEN/WORD_W) fetch cycles + CHAIN_LEN shift cycles (+ CHAIN_LEN if verifying).

Reset
REQ-028 Config_Reset SHALL force IDLE, remaining=0, CRCs=0xFFFF, all outputs 0, at the next edge, including mid-FETCH/SHIFT/VERIFY.
REQ-029 Reset SHALL take priority over start and word handshake in the same cycle.

Structure
REQ-030 Package config_loader_pkg SHALL hold the state enum, CRC_POLY=0x1021, CRC_INIT=0xFFFF.
REQ-031 Sub-module crc16_serial (clear, enable, bit_in, crc_out) SHALL be instantiated twice (CRC_A, CRC_B).

Verification
REQ-032 CHAIN_LEN=5, word 0x00000015, verify off -> cfg_data 1,0,1,0,1 in cycles 2-6, done=1 cycle 7, busy=0.
REQ-033 CHAIN_LEN=40, words 0xFFFFFFFF then 0x000000A5, word_valid low 3 cycles before word 2 -> 32 ones, 4 cycles cfg_enable=0, then 1,0,1,0,0,1,0,1.
REQ-034 CHAIN_LEN=5, verify on, 5-bit chain model -> 5 recirculate cycles, done=1, error=0, chain contents unchanged.
REQ-035 CHAIN_LEN=5, verify on, 6-bit chain model -> error=1, done=0.
REQ-036 Config_Reset high at 3rd SHIFT cycle -> next cycle IDLE, all outputs 0; new start loads cleanly.
REQ-037 start pulsed during SHIFT -> ignored, sequence and cycle count unchanged.

Source files
------------

// File: rtl/config_chain_loader_pkg.sv
// Shared types and CRC helpers for the configuration chain loader.
package config_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first bit-serial CRC-16-CCITT step.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Host word handshake: the host is the master, the loader is the slave.
interface config_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word_data;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/config_chain_loader_crc16.sv
// Bit-serial CRC-16-CCITT accumulator; clear wins over enable.
module crc16_serial
  import config_loader_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC_INIT;
    end else if (enable) begin
      crc_d = crc16_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/config_chain_loader.sv
// Loads host words LSB-first into a serial config chain, then optionally
// recirculates the chain once and compares CRCs of written and read-back bits.
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 5,
  parameter int WORD_W    = 32
) (
  input  logic                  Config_Clock,
  input  logic                  Config_Reset,
  input  logic                  start,
  input  logic                  verify_en,
  config_chain_loader_if.slave  host,
  output logic                  cfg_enable,
  output logic                  cfg_data,
  input  logic                  cfg_return,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int REM_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(CHAIN_LEN);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e            state_q, state_d;
  logic [REM_W-1:0]  remaining_q, remaining_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              verify_q, verify_d;

  logic              crc_clear;
  logic              shift_bit;
  logic              crc_match;
  logic [1:0]        crc_en;
  logic [1:0]        crc_bit;
  logic [15:0]       crc_val [2];

  assign shift_bit = word_q[bit_idx_q];

  // The readback CRC register lags one bit, so fold in the final returned bit here.
  assign crc_match = (crc16_step(crc_val[1], cfg_return) == crc_val[0]);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bit_idx_d   = bit_idx_q;
    word_d      = word_q;
    verify_d    = verify_q;
    crc_clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_FETCH;
          remaining_d = REM_FULL;
          verify_d    = verify_en;
          crc_clear   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (host.word_valid) begin
          word_d    = host.word_data;
          bit_idx_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        remaining_d = remaining_q - REM_ONE;
        bit_idx_d   = bit_idx_q + IDX_ONE;
        if (remaining_q == REM_ONE) begin
          if (verify_q) begin
            state_d     = ST_VERIFY;
            remaining_d = REM_FULL;
          end else begin
            state_d = ST_DONE;
          end
        end else if (bit_idx_q == IDX_LAST) begin
          state_d = ST_FETCH;
        end
      end
      ST_VERIFY: begin
        remaining_d = remaining_q - REM_ONE;
        if (remaining_q == REM_ONE) begin
          state_d = crc_match ? ST_DONE : ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Config_Clock) begin
    if (Config_Reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      bit_idx_q   <= '0;
      word_q      <= '0;
      verify_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      bit_idx_q   <= bit_idx_d;
      word_q      <= word_d;
      verify_q    <= verify_d;
    end
  end

  // Index 0 tracks bits written during SHIFT, index 1 bits read back during VERIFY.
  assign crc_en  = {state_q == ST_VERIFY, state_q == ST_SHIFT};
  assign crc_bit = {cfg_return, shift_bit};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_crc
      crc16_serial u_crc (
        .clk    (Config_Clock),
        .srst   (Config_Reset),
        .clear  (crc_clear),
        .enable (crc_en[gi]),
        .bit_in (crc_bit[gi]),
        .crc_out(crc_val[gi])
      );
    end
  endgenerate

  assign busy            = (state_q == ST_FETCH) || (state_q == ST_SHIFT) || (state_q == ST_VERIFY);
  assign done            = (state_q == ST_DONE);
  assign error           = (state_q == ST_ERROR);
  assign host.word_ready = (state_q == ST_FETCH);
  assign cfg_enable      = (state_q == ST_SHIFT) || (state_q == ST_VERIFY);

  always_comb begin
    cfg_data = 1'b0;
    if (state_q == ST_SHIFT) begin
      cfg_data = shift_bit;
    end else if (state_q == ST_VERIFY) begin
      cfg_data = cfg_return;
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed, table-driven checks of a 5-bit and a 40-bit loader against hand-computed
// per-cycle outputs, with a behavioural chain model supplying cfg_return.
module tb_config_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start5, verify5, ret5, en5, data5, busy5, done5, err5;
  logic start40, verify40, ret40, en40, data40, busy40, done40, err40;

  config_chain_loader_if #(.WORD_W(32)) host5 ();
  config_chain_loader_if #(.WORD_W(32)) host40 ();

  config_chain_loader #(.CHAIN_LEN(5), .WORD_W(32)) dut5 (
    .Config_Clock(clk), .Config_Reset(rst), .start(start5), .verify_en(verify5),
    .host(host5.slave), .cfg_enable(en5), .cfg_data(data5), .cfg_return(ret5),
    .busy(busy5), .done(done5), .error(err5)
  );

  config_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut40 (
    .Config_Clock(clk), .Config_Reset(rst), .start(start40), .verify_en(verify40),
    .host(host40.slave), .cfg_enable(en40), .cfg_data(data40), .cfg_return(ret40),
    .busy(busy40), .done(done40), .error(err40)
  );

  // Chain model: cell 0 takes cfg_data, the last cell (length chain_len_m) drives cfg_return.
  logic [63:0] chain;
  int          chain_len_m = 5;
  logic        chain_clr;
  always @(posedge clk) begin
    if (chain_clr) chain <= '0;
    else if (en5)  chain <= {chain[62:0], data5};
  end
  assign ret5  = chain[chain_len_m-1];
  assign ret40 = 1'b0;

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic        verify;
    logic        wv;
    logic [31:0] wd;
    int          clen;
    logic        clr;
    logic [5:0]  exp;   // {busy, word_ready, cfg_enable, cfg_data, done, error}
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string n, logic r, logic s, logic v, logic wv,
                              logic [31:0] wd, int clen, logic clr, logic [5:0] e);
    vec_t t;
    t.name = n; t.rst = r; t.start = s; t.verify = v; t.wv = wv;
    t.wd = wd; t.clen = clen; t.clr = clr; t.exp = e;
    return t;
  endfunction

  task automatic add(string n, logic r, logic s, logic v, logic wv,
                     logic [31:0] wd, int clen, logic clr, logic [5:0] e);
    vq.push_back(mk(n, r, s, v, wv, wd, clen, clr, e));
  endtask

  task automatic apply(input vec_t v);
    logic [5:0] got;
    rst               = v.rst;
    start5            = v.start;
    verify5           = v.verify;
    host5.word_valid  = v.wv;
    host5.word_data   = v.wd;
    chain_len_m       = v.clen;
    chain_clr         = v.clr;
    @(negedge clk);
    got = {busy5, host5.word_ready, en5, data5, done5, err5};
    n_vec++;
    if (got !== v.exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (busy,ready,en,data,done,error)", v.name, got, v.exp);
    end else begin
      $display("ok   %s: %b", v.name, got);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_table();
    foreach (vq[i]) apply(vq[i]);
    vq.delete();
  endtask

  task automatic add_shift5(string p, logic [4:0] bits, int clen, logic r_at2);
    for (int i = 0; i < 5; i++)
      add($sformatf("%s_shift%0d", p, i), (i == 2) ? r_at2 : 1'b0, 1'b0, 1'b0, 1'b1,
          32'h0, clen, 1'b0, {3'b101, bits[i], 2'b00});
  endtask

  initial begin
    rst = 1'b1; chain_clr = 1'b1;
    start5 = 0; verify5 = 0; host5.word_valid = 0; host5.word_data = '0;
    start40 = 0; verify40 = 0; host40.word_valid = 0; host40.word_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then plain load of 0x15 (bits 1,0,1,0,1) without verify.
    add("reset_idle", 0, 0, 0, 0, 32'h0,  5, 0, 6'b000000);
    add("a_start",    0, 1, 0, 1, 32'h15, 5, 0, 6'b000000);
    add("a_fetch",    0, 0, 0, 1, 32'h15, 5, 0, 6'b110000);
    add_shift5("a", 5'b10101, 5, 1'b0);
    add("a_done",     0, 0, 0, 0, 32'h0,  5, 0, 6'b000010);
    add("a_hold",     0, 0, 0, 0, 32'h0,  5, 0, 6'b000010);
    // Load 0x0D (bits 1,0,1,1,0) with verify on a matching 5-bit chain.
    add("b_start",    0, 1, 1, 1, 32'h0D, 5, 0, 6'b000010);
    add("b_fetch",    0, 0, 0, 1, 32'h0D, 5, 0, 6'b110000);
    add_shift5("b", 5'b01101, 5, 1'b0);
    add_shift5("b_verify", 5'b01101, 5, 1'b0);
    add("b_done",     0, 0, 0, 0, 32'h0,  5, 0, 6'b000010);
    run_table();

    n_vec++;
    if (chain[4:0] !== 5'b10110) begin
      n_bad++;
      $display("FAIL b_chain: got %b required %b", chain[4:0], 5'b10110);
    end else $display("ok   b_chain: %b", chain[4:0]);

    // Same load into a 6-bit chain: readback is 0,1,0,1,1 so the CRCs differ.
    add("c_start",    0, 1, 1, 1, 32'h0D, 6, 1, 6'b000010);
    add("c_fetch",    0, 0, 0, 1, 32'h0D, 6, 0, 6'b110000);
    add_shift5("c", 5'b01101, 6, 1'b0);
    add_shift5("c_verify", 5'b11010, 6, 1'b0);
    add("c_error",    0, 0, 0, 0, 32'h0,  6, 0, 6'b000001);
    add("c_hold",     0, 0, 0, 0, 32'h0,  6, 0, 6'b000001);
    // Start held high through FETCH and SHIFT is ignored.
    add("d_start",    0, 1, 0, 1, 32'h15, 5, 0, 6'b000001);
    add("d_fetch",    0, 1, 0, 1, 32'h15, 5, 0, 6'b110000);
    for (int i = 0; i < 5; i++)
      add($sformatf("d_shift%0d", i), 0, 1, 0, 1, 32'h0, 5, 0, {3'b101, ((i % 2) == 0), 2'b00});
    add("d_done",     0, 0, 0, 0, 32'h0,  5, 0, 6'b000010);
    // Reset during the third SHIFT cycle, then a clean reload.
    add("e_start",    0, 1, 0, 1, 32'h15, 5, 0, 6'b000010);
    add("e_fetch",    0, 0, 0, 1, 32'h15, 5, 0, 6'b110000);
    add("e_shift0",   0, 0, 0, 1, 32'h0,  5, 0, 6'b101100);
    add("e_shift1",   0, 0, 0, 1, 32'h0,  5, 0, 6'b101000);
    add("e_shift2_rst", 1, 0, 0, 1, 32'h0, 5, 0, 6'b101100);
    add("e_idle",     0, 0, 0, 0, 32'h0,  5, 0, 6'b000000);
    add("e_restart",  0, 1, 0, 1, 32'h15, 5, 0, 6'b000000);
    add("e_fetch2",   0, 0, 0, 1, 32'h15, 5, 0, 6'b110000);
    add_shift5("e2", 5'b10101, 5, 1'b0);
    add("e_done",     0, 0, 0, 0, 32'h0,  5, 0, 6'b000010);
    // Reset beats a handshake and a start in the same cycle.
    add("f_start",    0, 1, 0, 0, 32'h15, 5, 0, 6'b000010);
    add("f_fetch_rst", 1, 0, 0, 1, 32'h15, 5, 0, 6'b110000);
    add("f_idle",     0, 0, 0, 0, 32'h0,  5, 0, 6'b000000);
    add("f_rst_start", 1, 1, 0, 0, 32'h0, 5, 0, 6'b000000);
    add("f_idle2",    0, 0, 0, 0, 32'h0,  5, 0, 6'b000000);
    // Reset during VERIFY.
    add("g_start",    0, 1, 1, 1, 32'h0D, 5, 0, 6'b000000);
    add("g_fetch",    0, 0, 0, 1, 32'h0D, 5, 0, 6'b110000);
    add_shift5("g", 5'b01101, 5, 1'b0);
    add("g_verify_rst", 1, 0, 0, 0, 32'h0, 5, 0, 6'b101100);
    add("g_idle",     0, 0, 0, 0, 32'h0,  5, 0, 6'b000000);
    run_table();

    // 40-bit load: 0xFFFFFFFF, 3-cycle host stall, then 0xA5 of which 8 bits are used.
    begin
      logic [7:0] w2;
      logic [4:0] got, exp;
      logic       e_en, e_d;
      w2 = 8'hA5;
      for (int c = 0; c < 48; c++) begin
        start40           = (c == 0);
        host40.word_valid = (c == 1) || (c == 37);
        host40.word_data  = (c == 37) ? 32'h0000_00A5 : 32'hFFFF_FFFF;
        e_en = ((c >= 2) && (c <= 33)) || ((c >= 38) && (c <= 45));
        e_d  = ((c >= 2) && (c <= 33)) ? 1'b1 : (((c >= 38) && (c <= 45)) ? w2[c-38] : 1'b0);
        exp  = {(c >= 1) && (c <= 45), (c == 1) || ((c >= 34) && (c <= 37)), e_en, e_d, c >= 46};
        @(negedge clk);
        got = {busy40, host40.word_ready, en40, data40, done40};
        n_vec++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL len40_c%0d: got %b required %b (busy,ready,en,data,done)", c, got, exp);
        end else begin
          $display("ok   len40_c%0d: %b", c, got);
        end
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
